// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//
// Sequencer for the MEM-stage data-memory access. It splits each CPU word
// read or write into two half-word accesses on an external SRAM. The low
// half goes first, then the high half. Each half-access is held for
// WAIT_CYCLES clock cycles.
//
// Handshake: a request (rd_en / wr_en) is accepted only while the sequencer
// is idle. The requester keeps it asserted and is held by `freeze` until the
// one-cycle `ready` pulse. A transaction that has started always runs to
// completion, even if the request drops; it stops early only on reset.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   rd_en, wr_en    read / write request (a write wins if both are high)
//   address         byte address; word index taken from [ADDR_WIDTH:2]
//   write_data      store data
//   read_data       last completed read word (registered)
//   ready           one-cycle completion pulse (registered)
//   freeze          pipeline hold, (rd_en|wr_en) & ~ready (combinational)
//   sram_addr       half-word address (registered)
//   sram_wdata      half-word write data (registered)
//   sram_rdata      half-word read data from the SRAM
//   sram_we_n       active-low write enable (registered)
module mem_access_ctrl #(
  parameter int BIT_NUMBER  = 32,
  parameter int ADDR_WIDTH  = 18,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic                    wr_en,
  input  logic [BIT_NUMBER-1:0]   address,
  input  logic [BIT_NUMBER-1:0]   write_data,
  output logic [BIT_NUMBER-1:0]   read_data,
  output logic                    ready,
  output logic                    freeze,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [BIT_NUMBER/2-1:0] sram_wdata,
  input  logic [BIT_NUMBER/2-1:0] sram_rdata,
  output logic                    sram_we_n
);

  localparam int HALF = BIT_NUMBER / 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-2:0] word_idx;
  logic [BIT_NUMBER-1:0] wdata_q;
  logic                  is_write;
  logic [HALF-1:0]       stage_lo;

  // Address bits outside the word index are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[BIT_NUMBER-1:ADDR_WIDTH+1], address[1:0]};

  assign freeze = (rd_en | wr_en) & ~ready;

  // The SRAM-side outputs are registered. They are loaded on the same edge
  // that enters each half, so they are already valid in the first cycle of
  // that half and stay stable for all of its cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      word_idx   <= '0;
      wdata_q    <= '0;
      is_write   <= 1'b0;
      stage_lo   <= '0;
      read_data  <= '0;
      ready      <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            word_idx   <= address[ADDR_WIDTH:2];
            wdata_q    <= write_data;
            is_write   <= wr_en;
            cnt        <= '0;
            state      <= LOW;
            sram_addr  <= {address[ADDR_WIDTH:2], 1'b0};
            sram_wdata <= write_data[HALF-1:0];
            sram_we_n  <= ~wr_en;
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            if (!is_write) stage_lo <= sram_rdata;
            cnt        <= '0;
            state      <= HIGH;
            // sram_we_n is not reloaded here, so a write holds it low
            // across the change from the low half to the high half.
            sram_addr  <= {word_idx, 1'b1};
            sram_wdata <= wdata_q[BIT_NUMBER-1:HALF];
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            if (!is_write) read_data <= {sram_rdata, stage_lo};
            cnt        <= '0;
            state      <= DONE;
            ready      <= 1'b1;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//
// Runs two instances of mem_access_ctrl, one with WAIT_CYCLES=4 and one with
// WAIT_CYCLES=1. Both share a half-word SRAM model, and `sel` chooses which
// instance is being driven. The expected outputs come from cycle-index
// arithmetic relative to the request cycle and from a word-level shadow of
// memory contents.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_en, wr_en, sel;
  logic [31:0] address, write_data;

  logic rd4, wr4, rd1, wr1;
  assign rd4 = rd_en & ~sel;
  assign wr4 = wr_en & ~sel;
  assign rd1 = rd_en & sel;
  assign wr1 = wr_en & sel;

  logic [31:0] read_data4, read_data1;
  logic        ready4, ready1, freeze4, freeze1, we_n4, we_n1;
  logic [17:0] sram_addr4, sram_addr1;
  logic [15:0] wdata4, wdata1, rdata4, rdata1;

  mem_access_ctrl #(.BIT_NUMBER(32), .ADDR_WIDTH(18), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .rd_en(rd4), .wr_en(wr4), .address(address),
    .write_data(write_data), .read_data(read_data4), .ready(ready4),
    .freeze(freeze4), .sram_addr(sram_addr4), .sram_wdata(wdata4),
    .sram_rdata(rdata4), .sram_we_n(we_n4));

  mem_access_ctrl #(.BIT_NUMBER(32), .ADDR_WIDTH(18), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(address),
    .write_data(write_data), .read_data(read_data1), .ready(ready1),
    .freeze(freeze1), .sram_addr(sram_addr1), .sram_wdata(wdata1),
    .sram_rdata(rdata1), .sram_we_n(we_n1));

  // Outputs of the instance being driven
  logic [31:0] m_rdata;
  logic        m_ready, m_freeze, m_we_n;
  logic [17:0] m_addr;
  logic [15:0] m_wdata;
  assign m_rdata  = sel ? read_data1 : read_data4;
  assign m_ready  = sel ? ready1     : ready4;
  assign m_freeze = sel ? freeze1    : freeze4;
  assign m_we_n   = sel ? we_n1      : we_n4;
  assign m_addr   = sel ? sram_addr1 : sram_addr4;
  assign m_wdata  = sel ? wdata1     : wdata4;

  function automatic logic [15:0] pat(input int i);
    return 16'hA000 | 16'(i);
  endfunction

  // SRAM model: 64 half-words, aliased on the low address bits. Contents
  // are loaded with pat() while rst is low.
  logic [15:0] mem [0:63];
  assign rdata4 = mem[sram_addr4[5:0]];
  assign rdata1 = mem[sram_addr1[5:0]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else begin
      if (!we_n4) mem[sram_addr4[5:0]] <= wdata4;
      if (!we_n1) mem[sram_addr1[5:0]] <= wdata1;
    end
  end

  // Word-level reference: 32 words indexed by address[6:2]
  logic [31:0] shadow [0:31];
  logic [31:0] exp_rd [0:1];

  task automatic init_model();
    for (int i = 0; i < 32; i++) shadow[i] = {pat(2*i+1), pat(2*i)};
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Starts in the IDLE cycle (right after a negedge) and returns during the
  // DONE cycle. Cycle k counts from the cycle in which the request is first
  // presented. drop_at >= 1 removes the request from that cycle onward.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int drop_at, input logic w1,
                         output logic saw_we_low);
    int          w;
    logic        is_wr, active, hi, req;
    logic [4:0]  idx;
    logic [17:0] base;
    logic [31:0] rd_before, rd_after, exp_wd;
    sel = w1;
    w = w1 ? 1 : 4;
    is_wr = wr;
    idx = a[6:2];
    base = {a[18:2], 1'b0};
    rd_before = exp_rd[w1];
    if (is_wr) shadow[idx] = wd;
    else exp_rd[w1] = shadow[idx];
    rd_after = exp_rd[w1];
    saw_we_low = 1'b0;
    rd_en = rd; wr_en = wr; address = a; write_data = wd;
    for (int k = 0; k <= 2*w+1; k++) begin
      if (k > 0) @(negedge clk);
      if (drop_at >= 1 && k >= drop_at) begin rd_en = 1'b0; wr_en = 1'b0; end
      #1;
      active = (k >= 1) && (k <= 2*w);
      hi = (k > w);
      req = (drop_at < 1 || k < drop_at) ? (rd | wr) : 1'b0;
      exp_wd = !active ? 32'd0 : hi ? {16'd0, wd[31:16]} : {16'd0, wd[15:0]};
      if (!m_we_n) saw_we_low = 1'b1;
      chk("sram_addr", {14'd0, m_addr}, active ? {14'd0, base | {17'd0, hi}} : 32'd0);
      chk("sram_we_n", {31'd0, m_we_n}, (active && is_wr) ? 32'd0 : 32'd1);
      chk("sram_wdata", {16'd0, m_wdata}, exp_wd);
      chk("ready", {31'd0, m_ready}, (k == 2*w+1) ? 32'd1 : 32'd0);
      chk("freeze", {31'd0, m_freeze}, (req && k != 2*w+1) ? 32'd1 : 32'd0);
      chk("read_data", m_rdata, (k == 2*w+1) ? rd_after : rd_before);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          drop_at;
    logic        w1;
    logic        b2b;
    logic        exp_we_low;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw;
    logic        r, wv, w1b;
    int          op, w, drop;
    logic [31:0] ra, rw;

    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; sel = 1'b0;
    address = 32'd0; write_data = 32'd0;
    init_model();
    repeat (3) @(negedge clk);
    chk("rst ready4", {31'd0, ready4}, 32'd0);
    chk("rst we_n4", {31'd0, we_n4}, 32'd1);
    chk("rst addr4", {14'd0, sram_addr4}, 32'd0);
    chk("rst wdata4", {16'd0, wdata4}, 32'd0);
    chk("rst rdata4", read_data4, 32'd0);
    chk("rst ready1", {31'd0, ready1}, 32'd0);
    chk("rst we_n1", {31'd0, we_n1}, 32'd1);
    chk("rst rdata1", read_data1, 32'd0);
    rst = 1'b1;

    // rd, wr, address, wdata, drop_at, w1, b2b, exp_we_low, exp_rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, -1, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, -1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678, -1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, -1, 1'b0, 1'b0, 1'b0, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0018, 32'h5555_AAAA,  2, 1'b0, 1'b0, 1'b0, 32'hA00D_A00C};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, -1, 1'b1, 1'b0, 1'b0, 32'hA003_A002};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, -1, 1'b1, 1'b1, 1'b0, 32'hA005_A004};

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!vecs[i].b2b) @(negedge clk);
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].drop_at,
              vecs[i].w1, saw);
      chk("vec we_low", {31'd0, saw}, {31'd0, vecs[i].exp_we_low});
      chk("vec read_data", m_rdata, vecs[i].exp_rdata);
    end

    // Random traffic on both instances
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      r = (op != 1);
      wv = (op != 0);
      w1b = 1'($urandom_range(0, 1));
      w = w1b ? 1 : 4;
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2*w) : -1;
      ra = $urandom;
      rw = $urandom;
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_txn(r, wv, ra, rw, drop, w1b, saw);
    end

    // Reset in the middle of a read on the WAIT_CYCLES=4 instance
    @(negedge clk);
    @(negedge clk);
    sel = 1'b0; rd_en = 1'b1; address = 32'h0000_0020; write_data = 32'd0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    init_model();
    #1;
    chk("midrst ready", {31'd0, ready4}, 32'd0);
    chk("midrst we_n", {31'd0, we_n4}, 32'd1);
    chk("midrst addr", {14'd0, sram_addr4}, 32'd0);
    chk("midrst wdata", {16'd0, wdata4}, 32'd0);
    chk("midrst read_data", read_data4, exp_rd[0]);
    chk("midrst read_data1", read_data1, exp_rd[1]);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("midrst no ready", {31'd0, ready4}, 32'd0);
      chk("midrst idle we_n", {31'd0, we_n4}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage's data-memory access. It turns single-cycle read and write requests from the EXE/MEM pipeline into multi-cycle transactions on an external half-word-wide SRAM. It asserts `freeze` to hold the upstream pipeline registers until the access completes. A completed read delivers a full word on `read_data`, timed for capture by the MEM-stage pipeline register.

## Interface
Parameters:
- `BIT_NUMBER`, 32: CPU word width; must be even. The SRAM data width is BIT_NUMBER/2.
- `ADDR_WIDTH`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 4: cycles each SRAM half-access is held; legal range 1..15.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `rd_en`  in  1  read request (MEM_R_EN of the instruction in MEM).
- `wr_en`  in  1  write request (MEM_W_EN of the instruction in MEM).
- `address`  in  BIT_NUMBER  byte address; word-aligned, bits [1:0] ignored.
- `write_data`  in  BIT_NUMBER  store data.
- `read_data`  out  BIT_NUMBER  last completed read word.
- `ready`  out  1  one-cycle pulse when a transaction completes.
- `freeze`  out  1  pipeline hold request.
- `sram_addr`  out  ADDR_WIDTH  SRAM half-word address.
- `sram_wdata`  out  BIT_NUMBER/2  SRAM write data.
- `sram_rdata`  in  BIT_NUMBER/2  SRAM read data, valid while address is held.
- `sram_we_n`  out  1  SRAM write enable, active low.

## Operation
- States: IDLE, LOW, HIGH, DONE. A wait counter `cnt` counts 0..WAIT_CYCLES-1.
- **IDLE**
  - If `wr_en` or `rd_en` is high: latch `address[ADDR_WIDTH:2]` as the word index, latch `write_data`, and latch the operation. Go to LOW with `cnt`=0.
  - If `wr_en` and `rd_en` are both high, the operation is a write; the read is dropped.
- **LOW**
  - Drive `sram_addr`={word index,1'b0} and `sram_wdata`=write_data[BIT_NUMBER/2-1:0].
  - `sram_we_n`=0 for a write, 1 for a read.
  - When `cnt`==WAIT_CYCLES-1: for a read, capture `sram_rdata` into the low half of a staging buffer. Then go to HIGH with `cnt`=0.
  - Otherwise increment `cnt`.
- **HIGH**
  - Same as LOW, with `sram_addr`={word index,1'b1} and the upper data half.
  - On exit, go to DONE. For a read, `read_data` <= {sram_rdata, staged low half} at that edge.
- **DONE**
  - `ready`=1 and `sram_we_n`=1; go to IDLE.
- Outside LOW/HIGH: `sram_addr`=0, `sram_wdata`=0, `sram_we_n`=1.
- `freeze` = (`rd_en`|`wr_en`) & ~`ready`. This is the only combinational output.
- `read_data` holds its value until the next read completes; writes do not change it.
- Requests are latched in IDLE only. Input changes during LOW/HIGH are ignored, and a started transaction always runs to DONE even if the request drops.
- **Reset** (`rst`=0 at an edge), including mid-transaction:
  - Go to IDLE; clear `cnt`, `read_data`, and the staging buffer.
  - Outputs after reset: `ready`=0, `sram_we_n`=1, `sram_addr`=0, `sram_wdata`=0.
  - A transaction aborted by reset never pulses `ready`.

## Timing
- Let W = WAIT_CYCLES, and let a request first be seen in IDLE at edge 0.
- LOW occupies cycles 1..W, HIGH occupies W+1..2W, and DONE is cycle 2W+1.
- `ready` is high exactly in cycle 2W+1. With W=4 that is cycle 9.
- `freeze` is high in cycles 0..2W (2W+1 cycles) while the request is held, and low in cycle 2W+1. The pipeline advances at the end of the DONE cycle.
- A new request present in the cycle after DONE starts at once: back-to-back accesses are 2W+2 cycles apart.
- `sram_addr`, `sram_wdata` and `sram_we_n` are registered. They are stable for all W cycles of each half, and `sram_we_n` never glitches between halves of one write.
- `sram_rdata` is sampled only at the last cycle of each half.

## Test plan
- **Reset mid-read.** With W=4, start a read and assert `rst`=0 at cycle 6 for 1 cycle.
  - Required: next cycle is IDLE with `ready`=0 and `sram_we_n`=1, and `read_data`=0.
- **Write.** With W=4, `wr_en`=1, `address`=0x0000_0010, `write_data`=0xDEAD_BEEF.
  - Cycles 1-4: `sram_addr`=8, `sram_wdata`=0xBEEF, `sram_we_n`=0.
  - Cycles 5-8: `sram_addr`=9, `sram_wdata`=0xDEAD.
  - Cycle 9: `ready`=1. `freeze` is high in cycles 0-8.
- **Read back.** Read `address`=0x0000_0010 with an SRAM model holding 8:0xBEEF and 9:0xDEAD.
  - Required: `read_data`=0xDEAD_BEEF in cycle 9, held until the next read completes.
- **Simultaneous enables.** `rd_en`=`wr_en`=1 → a write is performed (`sram_we_n`=0) and `read_data` is unchanged.
- **Minimum wait, back-to-back.** With W=1, issue two reads back-to-back at 0x4 and 0x8.
  - Required: `ready` in cycles 3 and 7, and `sram_addr` sequence 2,3,-,-,4,5.
- **Dropped request.** Deassert `rd_en` at cycle 2.
  - Required: the transaction still completes with `ready`=1 in cycle 2W+1, and `freeze`=0 from cycle 2 onward.
